// File: rtl/send.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// Latency: out goes low on the first edge after a rising order edge in IDLE; no backpressure, edges while busy are dropped.
module send #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       order,
  input  logic [7:0] data,
  output logic       sgn,
  output logic       out
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          order_q;
  logic [CW-1:0] baud;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bitcnt;
  logic [2:0]    bitcnt_nxt;
  logic [7:0]    shreg;
  logic [7:0]    shreg_nxt;
  logic          par;
  logic          par_nxt;
  logic          out_nxt;
  logic          sgn_nxt;
  logic          accept;
  logic          tick;

  // order_q follows order every cycle, busy or not, so a held level never retriggers
  assign accept = order & ~order_q & (state == IDLE);
  assign tick   = (state != IDLE) && (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bitcnt == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick && bitcnt == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    baud_nxt   = (state == IDLE || tick) ? '0 : baud + CW'(1);
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    par_nxt    = par;
    if (accept) begin
      shreg_nxt = data;
      par_nxt   = ^data;
    end
    if (tick) begin
      // bitcnt counts data bits in DATA and stop bits in STOP
      bitcnt_nxt = (state_nxt != state) ? 3'd0 : bitcnt + 3'd1;
      if (state == DATA && state_nxt == DATA) begin
        shreg_nxt = {1'b0, shreg[7:1]};
      end
    end
  end

  // out is computed from the next state so the line itself comes straight from a flop
  always_comb begin
    sgn_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   out_nxt = 1'b0;
      DATA:    out_nxt = shreg_nxt[0];
      PARITY:  out_nxt = par;
      default: out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      order_q <= 1'b0;
      baud    <= '0;
      bitcnt  <= 3'd0;
      shreg   <= 8'd0;
      par     <= 1'b0;
      out     <= 1'b1;
      sgn     <= 1'b0;
    end else begin
      order_q <= order;
      baud    <= baud_nxt;
      bitcnt  <= bitcnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      out     <= out_nxt;
      sgn     <= sgn_nxt;
    end
  end

endmodule

// File: tb/tb_send.sv
// Directed bench for send: a default 8N1 instance and an 8E2 instance, 16 clocks per bit.
module tb_send;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       order = 1'b0;
  logic [7:0] data = 8'h00;
  logic       sgn;
  logic       out;
  logic       order2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       sgn2;
  logic       out2;

  int total = 0;
  int npass = 0;

  send #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .order(order), .data(data), .sgn(sgn), .out(out)
  );

  send #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .order(order2), .data(data2), .sgn(sgn2), .out(out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called right after the negedge on which order rose; each bit must hold all 16 samples.
  task automatic frame_chk(input string tag, input bit which, input logic [11:0] exp, input int nbits);
    logic [15:0] os;
    logic [15:0] ss;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        os[c] = which ? out2 : out;
        ss[c] = which ? sgn2 : sgn;
      end
      check($sformatf("%s_bit%0d", tag, b), {16'd0, os}, {16'd0, {16{exp[b]}}});
      check($sformatf("%s_sgn%0d", tag, b), {16'd0, ss}, 32'h0000_FFFF);
    end
    @(negedge clk);
    check($sformatf("%s_end", tag), which ? {30'd0, sgn2, out2} : {30'd0, sgn, out}, 32'd1);
  endtask

  task automatic idle_chk(input string tag, input bit which, input int n);
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (which ? (out2 !== 1'b1 || sgn2 !== 1'b0) : (out !== 1'b1 || sgn !== 1'b0)) bad = 1'b1;
    end
    check(tag, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    // reset held 10 cycles with order low
    idle_chk("reset_hold", 1'b0, 10);
    check("reset_hold2", {30'd0, sgn2, out2}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    idle_chk("post_reset_idle", 1'b0, 20);
    check("post_reset_idle2", {30'd0, sgn2, out2}, 32'd1);

    // A5 with order held 50 cycles: one frame only
    @(negedge clk);
    data  = 8'hA5;
    order = 1'b1;
    fork
      frame_chk("a5", 1'b0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
      begin
        repeat (50) @(negedge clk);
        order = 1'b0;
      end
    join
    idle_chk("a5_no_second", 1'b0, 40);

    // data changes mid-frame must not leak into the frame
    @(negedge clk);
    data  = 8'h3C;
    order = 1'b1;
    fork
      frame_chk("3c", 1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
      begin
        repeat (20) @(negedge clk);
        data  = 8'h00;
        order = 1'b0;
      end
    join
    idle_chk("3c_idle", 1'b0, 20);

    // second rising edge at cycle 40 is dropped
    @(negedge clk);
    data  = 8'hC3;
    order = 1'b1;
    fork
      frame_chk("c3", 1'b0, {2'b00, 1'b1, 8'hC3, 1'b0}, 10);
      begin
        repeat (5) @(negedge clk);
        order = 1'b0;
        repeat (35) @(negedge clk);
        order = 1'b1;
        repeat (5) @(negedge clk);
        order = 1'b0;
      end
    join
    idle_chk("c3_no_second", 1'b0, 40);

    // reset at cycle 70 aborts asynchronously
    @(negedge clk);
    data  = 8'hF0;
    order = 1'b1;
    repeat (70) @(negedge clk);
    check("midframe_busy", {31'd0, sgn}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_line", {30'd0, sgn, out}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_hold", {30'd0, sgn, out}, 32'd1);
    // order still high at release starts a frame on the first edge
    rst  = 1'b1;
    data = 8'h81;
    frame_chk("81_after_rst", 1'b0, {2'b00, 1'b1, 8'h81, 1'b0}, 10);
    order = 1'b0;
    idle_chk("81_idle", 1'b0, 20);

    // parity / two stop bits, then a back-to-back frame
    @(negedge clk);
    data2  = 8'h07;
    order2 = 1'b1;
    fork
      frame_chk("par07", 1'b1, {2'b11, 1'b1, 8'h07, 1'b0}, 12);
      begin
        repeat (3) @(negedge clk);
        order2 = 1'b0;
      end
    join
    data2  = 8'h03;
    order2 = 1'b1;
    frame_chk("b2b03", 1'b1, {2'b11, 1'b0, 8'h03, 1'b0}, 12);
    order2 = 1'b0;
    idle_chk("b2b_idle", 1'b1, 20);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule

// File: doc/send.md
SEND -- requirements
Module: send

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after D7; 0 means no parity bit.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-006 order  input  1  transmit request, level input, may stay high for many cycles.
REQ-007 data  input  8  byte to transmit; sampled only at request acceptance.
REQ-008 sgn  output  1  busy flag; 1 while a frame is in progress.
REQ-009 out  output  1  serial TX line, idle high, registered.

Function
REQ-010 The block SHALL be an 8N1 UART transmitter (8E1/8N2 etc. per parameters), LSB first.
- Frame: start(0), D0..D7, optional parity, STOP_BITS stop bits (1).
REQ-011 A request SHALL be accepted only on a rising edge of order (order=1 this cycle, 0 previous cycle) while in IDLE.
- Order held high SHALL NOT retrigger.
- A rising edge while busy SHALL be ignored, with no queueing.
REQ-012 On acceptance, data SHALL be latched into a shift register.
- Later changes to data SHALL NOT affect the frame.
REQ-013 The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP.
- IDLE->START on acceptance.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->PARITY (PARITY_EN=1) or DATA->STOP after 8 bits.
- PARITY->STOP after one bit.
- STOP->IDLE after STOP_BITS bits.
REQ-014 out SHALL go low on the first clock edge after the accepting edge (latency 1 cycle).
- Each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-015 The total frame SHALL last (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles; the default is 160 cycles.
REQ-016 sgn SHALL rise on the same edge out goes low (start bit) and fall on the edge the final stop bit ends, as the FSM enters IDLE.
REQ-017 The parity bit SHALL equal the XOR of the 8 latched data bits.
REQ-018 A back-to-back request SHALL be accepted the cycle after returning to IDLE, provided a fresh rising edge of order occurs in IDLE.
- The edge detector SHALL track order continuously, including while busy.
REQ-019 The baud counter SHALL be sized as ceil(log2(CLKS_PER_BIT)) bits and SHALL wrap to 0 at CLKS_PER_BIT-1.
REQ-020 In IDLE, out SHALL be 1 and sgn SHALL be 0.

Reset
REQ-021 While rst=0, the following SHALL hold regardless of clk:
- out=1, sgn=0, FSM=IDLE.
- Baud and bit counters = 0, shift register = 0.
- Previous-order register = 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with out returning high asynchronously.
REQ-023 If order is already high at reset release, a rising edge SHALL be detected on the first clock edge after release and a frame SHALL start.

Verification
REQ-024 Reset held 10 cycles, order=0 -> out=1 and sgn=0 throughout, with no activity after release.
REQ-025 data=8'hA5, order pulsed high for 50 cycles (defaults) -> out sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; sgn high for exactly 160 cycles; exactly one frame sent.
REQ-026 data changed to 8'h00 at cycle 20 of a frame started with 8'h3C -> transmitted bits still encode 8'h3C.
REQ-027 Second rising edge of order at cycle 40 of a frame -> ignored; the line is idle after 160 cycles with no second frame.
REQ-028 rst pulled low at cycle 70 of a frame -> out=1 and sgn=0 immediately; the next request after release produces a complete correct frame.
REQ-029 PARITY_EN=1, STOP_BITS=2, data=8'h07 -> parity bit 1; frame of 12 bit times (192 cycles) ending with 2 stop bits.
